// File: rtl/config_tile_framed_pkg.sv
//==============================================================================
// config_tile_pkg : shared header layout and load-state encoding for the tile
// Rev 1.0
//==============================================================================
`default_nettype none

package config_tile_pkg;

  localparam int HDR_W     = 3;
  localparam int HDR_SRC   = 0;
  localparam int HDR_MEMEN = 1;
  localparam int HDR_PAR   = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } tile_state_e;

endpackage

`default_nettype wire

// File: rtl/config_tile_framed_if.sv
//==============================================================================
// config_tile_framed_if : serial load / commit bus and active config outputs
// Rev 1.0
//==============================================================================
`default_nettype none

interface config_tile_framed_if #(
  parameter int COMB_W = 5,
  parameter int MEM_W  = 7
);

  logic              shift_in_hard;
  logic              shift_en_hard;
  logic              shift_in_soft;
  logic              shift_en_soft;
  logic              commit;
  logic [COMB_W-1:0] comb_config;
  logic [MEM_W-1:0]  mem_config;
  logic              shift_out;
  logic              config_valid;
  logic              frame_err;

  modport master (
    output shift_in_hard, shift_en_hard, shift_in_soft, shift_en_soft, commit,
    input  comb_config, mem_config, shift_out, config_valid, frame_err
  );

  modport slave (
    input  shift_in_hard, shift_en_hard, shift_in_soft, shift_en_soft, commit,
    output comb_config, mem_config, shift_out, config_valid, frame_err
  );

endinterface

`default_nettype wire

// File: rtl/config_shift_seg.sv
//==============================================================================
// config_shift_seg : enabled serial-in shift register, data moves toward MSB
// Rev 1.0
//==============================================================================
`default_nettype none

module config_shift_seg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_d,
  output logic [W-1:0] o_q,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= {r_q[W-2:0], i_d};
    end
  end

  assign o_q   = r_q;
  assign o_msb = r_q[W-1];

endmodule

`default_nettype wire

// File: rtl/config_tile_framed.sv
//==============================================================================
// config_tile_framed : double-buffered daisy-chain config tile with parity
// Rev 1.0
//==============================================================================
`default_nettype none

module config_tile_framed
  import config_tile_pkg::*;
#(
  parameter int COMB_W = 5,
  parameter int MEM_W  = 7
) (
  input logic                 clk,
  input logic                 rst,
  config_tile_framed_if.slave bus
);

  localparam int SEG_W = HDR_W + COMB_W;
  localparam int CNT_W = $clog2(SEG_W + MEM_W + 1);
  localparam logic [CNT_W-1:0] LEN_BYP = CNT_W'(SEG_W);
  localparam logic [CNT_W-1:0] LEN_MEM = CNT_W'(SEG_W + MEM_W);

  logic              r_act_src;
  logic              r_act_mem_en;
  logic [COMB_W-1:0] r_comb;
  logic [MEM_W-1:0]  r_mem;
  logic              r_valid;
  logic              r_err;
  logic [CNT_W-1:0]  r_bit_cnt;

  logic              w_sel_in;
  logic              w_sel_en;
  logic [SEG_W-1:0]  w_hc;
  logic              w_hc_msb;
  logic [MEM_W-1:0]  w_mem;
  logic              w_mem_msb;
  logic [CNT_W-1:0]  w_len;
  tile_state_e       w_state;
  logic              w_parity;
  logic              w_accept;

  // The unselected source pair never reaches the shadow.
  assign w_sel_in = r_act_src ? bus.shift_in_soft : bus.shift_in_hard;
  assign w_sel_en = r_act_src ? bus.shift_en_soft : bus.shift_en_hard;

  config_shift_seg #(.W(SEG_W)) u_hc (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_sel_en),
    .i_d   (w_sel_in),
    .o_q   (w_hc),
    .o_msb (w_hc_msb)
  );

  config_shift_seg #(.W(MEM_W)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_sel_en & r_act_mem_en),
    .i_d   (w_hc_msb),
    .o_q   (w_mem),
    .o_msb (w_mem_msb)
  );

  assign w_len = r_act_mem_en ? LEN_MEM : LEN_BYP;

  always_comb begin
    w_state = LOADING;
    if (r_bit_cnt == '0) begin
      w_state = EMPTY;
    end else if (r_bit_cnt == w_len) begin
      w_state = FULL;
    end
  end

  // Parity covers only the segments that are part of the current chain.
  assign w_parity = w_hc[HDR_PAR] ^ w_hc[HDR_MEMEN] ^ w_hc[HDR_SRC]
                  ^ (^w_hc[HDR_W +: COMB_W])
                  ^ (r_act_mem_en & (^w_mem));

  assign w_accept = bus.commit && (w_state == FULL) && !w_sel_en && !w_parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act_src    <= 1'b0;
      r_act_mem_en <= 1'b0;
      r_comb       <= '0;
      r_mem        <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_bit_cnt    <= '0;
    end else if (w_accept) begin
      r_act_src    <= w_hc[HDR_SRC];
      r_act_mem_en <= w_hc[HDR_MEMEN];
      r_comb       <= w_hc[HDR_W +: COMB_W];
      if (r_act_mem_en) begin
        r_mem <= w_mem;
      end
      r_valid      <= 1'b1;
      r_err        <= 1'b0;
      r_bit_cnt    <= '0;
    end else begin
      if (bus.commit) begin
        r_err <= 1'b1;
      end
      if (w_sel_en && (r_bit_cnt != w_len)) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.comb_config  = r_comb;
  assign bus.mem_config   = r_mem;
  assign bus.shift_out    = r_act_mem_en ? w_mem_msb : w_hc_msb;
  assign bus.config_valid = r_valid;
  assign bus.frame_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_config_tile_framed.sv
//==============================================================================
// tb_config_tile_framed : directed + randomized bench with a frame-level model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_config_tile_framed;

  localparam int COMB_W = 5;
  localparam int MEM_W  = 7;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  config_tile_framed_if #(.COMB_W(COMB_W), .MEM_W(MEM_W)) bus ();

  config_tile_framed #(.COMB_W(COMB_W), .MEM_W(MEM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: shadow as plain bit vectors plus the active view.
  logic [7:0] m_hc;
  logic [6:0] m_mem;
  int         m_cnt;
  logic       m_src, m_memen, m_valid, m_err;
  logic [4:0] m_comb;
  logic [6:0] m_memcfg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hc = '0; m_mem = '0; m_cnt = 0; m_src = 0; m_memen = 0;
    m_valid = 0; m_err = 0; m_comb = '0; m_memcfg = '0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".comb"},  32'(bus.comb_config),  32'(m_comb));
    chk({ctx, ".mem"},   32'(bus.mem_config),   32'(m_memcfg));
    chk({ctx, ".valid"}, 32'(bus.config_valid), 32'(m_valid));
    chk({ctx, ".err"},   32'(bus.frame_err),    32'(m_err));
    chk({ctx, ".sout"},  32'(bus.shift_out),    32'(m_memen ? m_mem[6] : m_hc[7]));
    chk({ctx, ".cnt"},   32'(dut.r_bit_cnt),    32'(m_cnt));
  endtask

  task automatic step(input logic hin, input logic hen, input logic sin,
                      input logic sen, input logic com);
    logic en, din, acc;
    int   len, ones;
    @(negedge clk);
    bus.shift_in_hard = hin; bus.shift_en_hard = hen;
    bus.shift_in_soft = sin; bus.shift_en_soft = sen;
    bus.commit = com;
    en   = m_src ? sen : hen;
    din  = m_src ? sin : hin;
    len  = m_memen ? 15 : 8;
    ones = $countones(m_hc) + (m_memen ? $countones(m_mem) : 0);
    acc  = com && (m_cnt == len) && !en && (ones % 2 == 0);
    @(posedge clk);
    #1;
    if (acc) begin
      if (m_memen) m_memcfg = m_mem;
      m_src = m_hc[0]; m_memen = m_hc[1]; m_comb = m_hc[7:3];
      m_valid = 1; m_err = 0; m_cnt = 0;
    end else begin
      if (com) m_err = 1;
      if (en) begin
        if (m_memen) m_mem = {m_mem[5:0], m_hc[7]};
        m_hc = {m_hc[6:0], din};
        if (m_cnt < len) m_cnt++;
      end
    end
    check_all("step");
  endtask

  // Drive the currently selected source; the other pair carries random noise.
  task automatic drive(input logic b, input logic en, input logic com);
    logic nb, ne;
    nb = 1'($urandom); ne = 1'($urandom);
    if (m_src) step(nb, ne, b, en, com);
    else       step(b, en, nb, ne, com);
  endtask

  task automatic send(input logic [14:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) drive(f[i], 1'b1, 1'b0);
  endtask

  task automatic do_commit();
    drive(1'($urandom), 1'b0, 1'b1);
  endtask

  function automatic logic [14:0] mk(input logic [4:0] c, input logic [6:0] m,
                                     input logic me, input logic sr, input logic wm);
    logic p;
    p  = (^{me, sr, c}) ^ (wm ? (^m) : 1'b0);
    mk = wm ? {m, c, p, me, sr} : {7'd0, c, p, me, sr};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation budget exhausted");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] f, g;
    logic [4:0]  r5;
    n_cmp = 0; n_err = 0;
    bus.shift_in_hard = 0; bus.shift_en_hard = 0;
    bus.shift_in_soft = 0; bus.shift_en_soft = 0; bus.commit = 0;
    rst = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst = 1'b1;

    // Bypass chain: L = 8, the lone 1 reaches shift_out on the 8th shift.
    drive(1'b1, 1'b1, 1'b0);
    repeat (7) drive(1'b0, 1'b1, 1'b0);
    chk("bypass_sout", 32'(bus.shift_out), 32'd1);
    do_commit();
    chk("bypass_badpar_err", 32'(bus.frame_err), 32'd1);
    send(mk(5'h0B, 7'h00, 1'b1, 1'b0, 1'b0), 8);
    do_commit();
    chk("bypass_comb", 32'(bus.comb_config), 32'h0B);
    chk("bypass_mem", 32'(bus.mem_config), 32'h00);
    chk("bypass_valid", 32'(bus.config_valid), 32'd1);
    chk("bypass_err_clr", 32'(bus.frame_err), 32'd0);

    // Full 15-bit good frame.
    f = mk(5'h16, 7'h01, 1'b1, 1'b0, 1'b1);
    send(f, 15);
    do_commit();
    chk("good_comb", 32'(bus.comb_config), 32'h16);
    chk("good_mem", 32'(bus.mem_config), 32'h01);
    chk("good_cnt", 32'(dut.r_bit_cnt), 32'd0);

    // Parity failure, then recovery.
    send(f ^ 15'h0004, 15);
    do_commit();
    chk("par_err", 32'(bus.frame_err), 32'd1);
    chk("par_comb_hold", 32'(bus.comb_config), 32'h16);
    send(f, 15);
    do_commit();
    chk("par_recover", 32'(bus.frame_err), 32'd0);

    // Early commit, then commit overlapping a shift.
    for (int i = 14; i >= 5; i--) drive(f[i], 1'b1, 1'b0);
    do_commit();
    chk("early_err", 32'(bus.frame_err), 32'd1);
    chk("early_cnt", 32'(dut.r_bit_cnt), 32'd10);
    for (int i = 4; i >= 0; i--) drive(f[i], 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    chk("overlap_err", 32'(bus.frame_err), 32'd1);
    send(f, 15);
    do_commit();

    // Overfeed: 20 bits, the first five leave through shift_out.
    r5 = 5'($urandom);
    g  = mk(5'h0A, 7'h55, 1'b1, 1'b0, 1'b1);
    for (int i = 4; i >= 0; i--) drive(r5[i], 1'b1, 1'b0);
    for (int k = 6; k <= 20; k++) begin
      drive(g[20 - k], 1'b1, 1'b0);
      if (k >= 15 && k <= 19) chk("overfeed_sout", 32'(bus.shift_out), 32'(r5[19 - k]));
    end
    do_commit();
    chk("overfeed_comb", 32'(bus.comb_config), 32'h0A);
    chk("overfeed_mem", 32'(bus.mem_config), 32'h55);

    // Source switch to soft; hard strobes must be ignored.
    send(mk(5'h03, 7'h12, 1'b1, 1'b1, 1'b1), 15);
    do_commit();
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'(i % 2), 1'b0, 1'b0, 1'b0);
    chk("soft_ignore_cnt", 32'(dut.r_bit_cnt), 32'd0);
    send(mk(5'h1F, 7'h7F, 1'b1, 1'b0, 1'b1), 15);
    do_commit();
    chk("soft_comb", 32'(bus.comb_config), 32'h1F);
    chk("soft_mem", 32'(bus.mem_config), 32'h7F);

    // Randomized frames: mixed lengths, corrupt parity, stray commits, gaps.
    for (int it = 0; it < 60; it++) begin
      logic [14:0] rf;
      int          n;
      n  = m_memen ? 15 : 8;
      rf = mk(5'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), m_memen);
      if ($urandom_range(0, 4) == 0) rf = rf ^ (15'd1 << $urandom_range(0, n - 1));
      repeat ($urandom_range(0, 3)) drive(1'($urandom), 1'b1, 1'b0);
      for (int i = n - 1; i >= 0; i--)
        drive(rf[i], 1'b1, 1'($urandom_range(0, 15) == 0));
      repeat ($urandom_range(0, 2)) drive(1'($urandom), 1'b0, 1'b0);
      do_commit();
    end

    // Asynchronous reset in the middle of a load.
    repeat (6) drive(1'($urandom), 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    chk("midreset_valid", 32'(bus.config_valid), 32'd0);
    @(negedge clk);
    bus.shift_en_hard = 0; bus.shift_en_soft = 0; bus.commit = 0;
    rst = 1'b1;
    do_commit();
    chk("midreset_commit_err", 32'(bus.frame_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
